// File: rtl/ymux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ymux2_rr_arbiter
//
// Shares one W-bit 2:1 mux datapath (sel 0 -> d0, sel 1 -> d1) between two
// requesters. A round-robin arbiter picks the winner, drives the mux select,
// and the chosen word is captured into an output register that is drained
// through a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req0/req1  requester has data (held with its data stable until granted)
//   d0/d1      requester data (mux input A / mux input B)
//   gnt0/gnt1  combinational grants; transfer happens at the edge where high
//   sel        mux select (winner on a grant, last winner when idle)
//   out_valid  out_data holds an unconsumed word
//   out_data   registered mux output
//   out_ready  consumer accepts out_data when high together with out_valid
//   cnt0/cnt1  (only with ARB_GRANT_CNT_EN) saturating 8-bit grant counts
//
// Optional feature macro: ARB_GRANT_CNT_EN
// ---------------------------------------------------------------------------
module ymux2_rr_arbiter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         sel,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
`ifdef ARB_GRANT_CNT_EN
   ,
   output logic [7:0]   cnt0,
   output logic [7:0]   cnt1
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e state, state_nxt;
   logic   last;
   logic   win;
   logic   grant;
   logic   slot_free;

   assign out_valid = (state == FULL);

   always_comb begin
      slot_free = (state == EMPTY) || out_ready;

      // Contention goes to the requester that did not win last time;
      // otherwise the lone requester wins (win is irrelevant with no request).
      if (req0 && req1) begin
         win = ~last;
      end else begin
         win = req1;
      end

      // rst_n gates the grant so nothing is offered while reset is held.
      grant = rst_n && slot_free && (req0 || req1);
      gnt0  = grant && !win;
      gnt1  = grant && win;
      sel   = grant ? win : last;

      state_nxt = state;
      if (grant) begin
         state_nxt = FULL;
      end else if ((state == FULL) && out_ready) begin
         state_nxt = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         last     <= 1'b1;
      end else if (grant) begin
         out_data <= sel ? d1 : d0;
         last     <= win;
      end
   end

`ifdef ARB_GRANT_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (gnt0 && (cnt0 != '1)) begin
            cnt0 <= cnt0 + 8'd1;
         end
         if (gnt1 && (cnt1 != '1)) begin
            cnt1 <= cnt1 + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ymux2_rr_arbiter.sv
module tb_ymux2_rr_arbiter;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0, req1;
   logic [W-1:0] d0, d1;
   logic         gnt0, gnt1, sel;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;
`ifdef ARB_GRANT_CNT_EN
   logic [7:0]   cnt0, cnt1;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   ymux2_rr_arbiter #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .req1      (req1),
      .d0        (d0),
      .d1        (d1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef ARB_GRANT_CNT_EN
      ,
      .cnt0      (cnt0),
      .cnt1      (cnt1)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic         m_valid;
   logic [W-1:0] m_data;
   int           m_last;
   int           m_cnt [2];

   function automatic void model_reset();
      m_valid  = 1'b0;
      m_data   = '0;
      m_last   = 1;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
   endfunction

   // Round-robin: scan requesters starting just after the last winner.
   function automatic void model_arb(input logic r0, input logic r1, input logic rdy,
                                     output logic g0, output logic g1, output logic s,
                                     output int w, output logic any);
      logic rq [2];
      int   idx;
      rq[0] = r0;
      rq[1] = r1;
      any   = 1'b0;
      w     = m_last;
      if (!m_valid || rdy) begin
         for (int k = 0; k < 2; k++) begin
            idx = (m_last + 1 + k) % 2;
            if (!any && rq[idx]) begin
               any = 1'b1;
               w   = idx;
            end
         end
      end
      g0 = any && (w == 0);
      g1 = any && (w == 1);
      s  = (w == 1);
   endfunction

   function automatic void model_edge();
      logic g0, g1, s, any;
      int   w;
      if (!rst_n) return;
      model_arb(req0, req1, out_ready, g0, g1, s, w, any);
      if (any) begin
         m_data  = (w == 1) ? d1 : d0;
         m_valid = 1'b1;
         m_last  = w;
         if (m_cnt[w] < 255) m_cnt[w] = m_cnt[w] + 1;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic drive(input logic r0, input logic r1, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic rdy);
      req0 = r0; req1 = r1; d0 = a; d1 = b; out_ready = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      drive(1'b1, 1'b1, 8'h5A, 8'hC3, 1'b1);
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_gnt: gnt0=%b gnt1=%b expected 0 0", gnt0, gnt1);
      end
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_out: valid=%b data=%h expected 0 00", out_valid, out_data);
      end
      n_cmp++;
      if (sel !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_sel: sel=%b expected 1 (last=1)", sel);
      end
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_req0();
      drive(1'b1, 1'b0, 8'hA5, 8'h00, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 1'b0) begin
         n_bad++;
         $display("FAIL single_req0_gnt: gnt0=%b gnt1=%b sel=%b expected 1 0 0", gnt0, gnt1, sel);
      end
      step();
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
         n_bad++;
         $display("FAIL single_req0_out: valid=%b data=%h expected 1 a5", out_valid, out_data);
      end
      step();
   endtask

   task automatic test_alternate();
      int g;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         g = i % 2;
         drive(1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
         @(negedge clk);
         n_cmp++;
         if (gnt0 !== (g == 0) || gnt1 !== (g == 1) || sel !== (g == 1)) begin
            n_bad++;
            $display("FAIL alternate_gnt[%0d]: gnt0=%b gnt1=%b sel=%b expected winner %0d", i, gnt0, gnt1, sel, g);
         end
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== ((g == 1) ? 8'h22 : 8'h11)) begin
            n_bad++;
            $display("FAIL alternate_out[%0d]: valid=%b data=%h expected 1 %h", i, out_valid, out_data,
                     (g == 1) ? 8'h22 : 8'h11);
         end
      end
   endtask

   task automatic test_backpressure();
      // Bring the arbiter to "just granted req1", at most two cycles.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
         step();
         if (m_last == 1) break;
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
         @(negedge clk);
         n_cmp++;
         if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_gnt[%0d]: gnt0=%b gnt1=%b expected 0 0", i, gnt0, gnt1);
         end
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            n_bad++;
            $display("FAIL backpressure_hold[%0d]: valid=%b data=%h expected 1 22", i, out_valid, out_data);
         end
      end
      drive(1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 1'b0) begin
         n_bad++;
         $display("FAIL backpressure_release: gnt0=%b gnt1=%b sel=%b expected 1 0 0", gnt0, gnt1, sel);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h11) begin
         n_bad++;
         $display("FAIL backpressure_next: valid=%b data=%h expected 1 11", out_valid, out_data);
      end
   endtask

   task automatic test_single_req1();
      logic [W-1:0] b;
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         drive(1'b0, 1'b1, 8'($urandom), b, 1'b1);
         @(negedge clk);
         n_cmp++;
         if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || sel !== 1'b1) begin
            n_bad++;
            $display("FAIL single_req1_gnt[%0d]: gnt0=%b gnt1=%b sel=%b expected 0 1 1", i, gnt0, gnt1, sel);
         end
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== b) begin
            n_bad++;
            $display("FAIL single_req1_out[%0d]: valid=%b data=%h expected 1 %h", i, out_valid, out_data, b);
         end
      end
   endtask

   task automatic test_random();
      logic eg0, eg1, es, any;
      int   w;
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(3) != 0));
         @(negedge clk);
         model_arb(req0, req1, out_ready, eg0, eg1, es, w, any);
         if (!any) es = (m_last == 1);
         n_cmp++;
         if (gnt0 !== eg0 || gnt1 !== eg1 || sel !== es) begin
            n_bad++;
            $display("FAIL random_gnt[%0d]: gnt0=%b gnt1=%b sel=%b expected %b %b %b", i, gnt0, gnt1, sel, eg0, eg1, es);
         end
         step();
         n_cmp++;
         if (out_valid !== m_valid || out_data !== m_data) begin
            n_bad++;
            $display("FAIL random_out[%0d]: valid=%b data=%h expected %b %h", i, out_valid, out_data, m_valid, m_data);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 8'h3C, 8'hC3, 1'b1);
         step();
      end
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: valid=%b data=%h gnt0=%b gnt1=%b expected 0 00 0 0",
                  out_valid, out_data, gnt0, gnt1);
      end
      step();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset_prio: gnt0=%b gnt1=%b sel=%b expected 1 0 0", gnt0, gnt1, sel);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
         n_bad++;
         $display("FAIL async_reset_first: valid=%b data=%h expected 1 3c", out_valid, out_data);
      end
   endtask

`ifdef ARB_GRANT_CNT_EN
   task automatic test_counters();
      apply_reset();
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 1'b0, 8'($urandom), 8'h00, 1'b1);
         step();
         if (i == 253) begin
            n_cmp++;
            if (cnt0 !== 8'd254 || cnt0 !== 8'(m_cnt[0])) begin
               n_bad++;
               $display("FAIL cnt0_pre_sat: cnt0=%0d expected 254", cnt0);
            end
         end
      end
      n_cmp++;
      if (cnt0 !== 8'd255 || cnt1 !== 8'd0) begin
         n_bad++;
         $display("FAIL cnt_saturate: cnt0=%0d cnt1=%0d expected 255 0", cnt0, cnt1);
      end
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      step();
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      rst_n = 1'b0;
      test_reset();
      test_single_req0();
      test_alternate();
      test_backpressure();
      test_single_req1();
      test_random();
      test_async_reset();
`ifdef ARB_GRANT_CNT_EN
      test_counters();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
